// File: rtl/accum_frame_n.sv
// accum_frame_n: frame accumulator over a valid/ready operand stream.
// A frame starts with a start pulse in IDLE. The block then sums len
// two's-complement operands into an N-bit running sum, using the n-bit
// add/carry/overflow rule of the adder stages. cout and overflow are
// sticky across the frame. The result is held in DONE until the consumer
// takes it.
// Optional feature: define ACCUM_SAT_EN to clamp the sum on signed
// overflow instead of letting it wrap.
module accum_frame_n #(
    parameter int N     = 16,
    parameter int LEN_W = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result word: the running sum together with its sticky flags.
    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    state_t           state;
    res_t             res_q;
    res_t             step;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [N:0]       wide;
    logic             step_ovf;
    logic             accept;
    logic             last;

    // Compute one accumulation step: widened add, signed-overflow detect, sticky merge.
    always_comb begin
        wide     = {1'b0, res_q.sum} + {1'b0, x};
        // The sum overflows when both operands have the same sign and the result sign differs.
        step_ovf = (res_q.sum[N-1] == x[N-1]) && (wide[N-1] != res_q.sum[N-1]);
        step.sum = wide[N-1:0];
`ifdef ACCUM_SAT_EN
        // Clamp toward the operand's sign. The carry still reflects the unclamped add.
        if (step_ovf) begin
            step.sum = x[N-1] ? SMIN : SMAX;
        end
`endif
        step.cout = res_q.cout | wide[N];
        step.ovf  = res_q.ovf | step_ovf;
    end

    // Handshake and last-operand decode. in_ready is only ever high in ACC.
    // len_q is nonzero in ACC, so count+1 never wraps past len_q.
    always_comb begin
        accept = in_ready & in_valid;
        last   = ((count + LEN_W'(1)) == len_q);
    end

    // Frame control FSM with registered handshake outputs and result.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            res_q     <= '0;
            len_q     <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        res_q <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        res_q <= step;
                        count <= count + LEN_W'(1);
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Hold the result until the consumer takes it. The values stay
                    // visible in IDLE until the next start clears them.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Drive the result outputs.
    always_comb begin
        sum      = res_q.sum;
        cout     = res_q.cout;
        overflow = res_q.ovf;
    end

endmodule

// File: tb/tb_accum_frame_n.sv
// Bench for accum_frame_n. It runs a cycle-level reference model built from
// integer arithmetic and checks the DUT against it on every falling edge,
// plus literal expectations taken from the worked examples.
module tb_accum_frame_n;

    localparam int N     = 16;
    localparam int LEN_W = 8;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     x = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    int total = 0;
    int bad   = 0;

    accum_frame_n #(.N(N), .LEN_W(LEN_W)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .overflow(overflow), .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. Phase 0 is idle, 1 is accumulating, 2 is holding a result.
    int           mph;
    int           mlen;
    int           mcnt;
    logic [N-1:0] msum;
    bit           mc;
    bit           mo;

    localparam longint SMAXV = (longint'(1) << (N-1)) - 1;
    localparam longint SMINV = -(longint'(1) << (N-1));

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mph = 0; mlen = 0; mcnt = 0; msum = '0; mc = 0; mo = 0;
        end else begin
            if (mph == 0) begin
                if (start) begin
                    mlen = int'(len); mcnt = 0; msum = '0; mc = 0; mo = 0;
                    mph = (len == 0) ? 2 : 1;
                end
            end else if (mph == 1) begin
                if (in_valid) begin
                    longint sa, sx, ua, ux, r, nv;
                    bit of;
                    sa = longint'($signed(msum));
                    sx = longint'($signed(x));
                    ua = longint'(msum);
                    ux = longint'(x);
                    r  = sa + sx;
                    of = (r > SMAXV) || (r < SMINV);
                    if ((ua + ux) >= (longint'(1) << N)) mc = 1;
                    if (of) mo = 1;
                    nv = r;
`ifdef ACCUM_SAT_EN
                    if (of) nv = (sx >= 0) ? SMAXV : SMINV;
`endif
                    msum = nv[N-1:0];
                    mcnt++;
                    if (mcnt == mlen) mph = 2;
                end
            end else begin
                if (out_ready) mph = 0;
            end
        end
    end

    // Compare the DUT against the model on every cycle.
    always @(negedge Clock) begin
        chk("in_ready", longint'(in_ready), longint'(mph == 1));
        chk("out_valid", longint'(out_valid), longint'(mph == 2));
        chk("busy", longint'(busy), longint'(mph != 0));
        chk("sum", longint'(sum), longint'(msum));
        chk("cout", longint'(cout), longint'(mc));
        chk("overflow", longint'(overflow), longint'(mo));
    end

    task automatic do_start(input int l);
        start = 1'b1; len = LEN_W'(l);
        @(negedge Clock);
        start = 1'b0; len = '0;
    endtask

    task automatic send(input logic [N-1:0] v);
        in_valid = 1'b1; x = v;
        @(negedge Clock);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge Clock);
        out_ready = 1'b0;
        chk("hs_idle", longint'({out_valid, busy}), 0);
    endtask

    // Wait for out_valid, giving up after a fixed number of cycles.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk({nm, "_timeout"}, longint'(out_valid), 1);
    endtask

    initial begin
        @(negedge Clock);
        chk("rst_state", longint'({in_ready, out_valid, busy, cout, overflow}), 0);
        chk("rst_sum", longint'(sum), 0);
        Resetn = 1'b1;
        @(negedge Clock);

        // 1: four operands back-to-back. out_valid must be high at the first check after the 4th accept.
        do_start(4);
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_sum", longint'(sum), 10);
        chk("t1_flags", longint'({cout, overflow}), 0);
        handshake();
        chk("t1_keep", longint'(sum), 10);

        // 2: signed overflow.
        do_start(2);
        send(16'h7FFF); send(16'h0001);
        wait_done("t2");
`ifdef ACCUM_SAT_EN
        chk("t2_sum", longint'(sum), 16'h7FFF);
`else
        chk("t2_sum", longint'(sum), 16'h8000);
`endif
        chk("t2_flags", longint'({cout, overflow}), 1);
        handshake();

        // 3: unsigned carry without signed overflow.
        do_start(2);
        send(16'hFFFF); send(16'h0001);
        wait_done("t3");
        chk("t3_sum", longint'(sum), 0);
        chk("t3_flags", longint'({cout, overflow}), 2);
        handshake();

        // 4: empty frame. Hold the result for 5 cycles, then take it.
        do_start(0);
        chk("t4_valid", longint'(out_valid), 1);
        chk("t4_sum", longint'(sum), 0);
        repeat (5) @(negedge Clock);
        chk("t4_hold", longint'({out_valid, busy, sum}), longint'({2'b11, 16'h0}));
        handshake();

        // 5: gapped operands. start pulses during ACC must be ignored.
        do_start(3);
        send(16'd5);
        start = 1'b1; len = 8'd0;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        send(-16'sd2);
        start = 1'b1; len = 8'd1;
        @(negedge Clock);
        start = 1'b0; len = '0;
        send(16'd7);
        chk("t5_valid", longint'(out_valid), 1);
        chk("t5_sum", longint'(sum), 10);
        handshake();

        // 6: reset mid-frame, then a fresh one-operand frame.
        do_start(4);
        send(16'd3); send(16'd4);
        #2 Resetn = 1'b0;
        #1;
        chk("t6_async", longint'({in_ready, out_valid, busy, cout, overflow}), 0);
        chk("t6_async_sum", longint'(sum), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        do_start(1);
        send(16'd9);
        chk("t6_valid", longint'(out_valid), 1);
        chk("t6_sum", longint'(sum), 9);
        handshake();

        repeat (3) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
